// File: rtl/agc_seq_pkg.sv
// Shared types and helpers for the AGC channel sequencer.
package agc_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_MEM,
    S_START,
    S_WAIT_PROC,
    S_EMIT,
    S_ADVANCE,
    S_DONE
  } state_t;

  localparam logic MODE_CONTINUOUS = 1'b0;
  localparam logic MODE_SINGLE     = 1'b1;

  // ROM address is {sample_idx, channel}: channels of one sample sit in adjacent words.
  function automatic logic [31:0] pack_addr(input logic [31:0] idx,
                                            input logic [31:0] ch,
                                            input int unsigned ch_w);
    return (idx << ch_w) | ch;
  endfunction

endpackage

// File: rtl/agc_position_counter.sv
// Channel / sample-index walker. Channel is the fast-moving digit.
module agc_position_counter #(
  parameter int NUM_CHANNELS = 4,
  parameter int DEPTH        = 256,
  parameter int CH_W         = 2,
  parameter int AW           = 8
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_advance,
  input  logic            i_clear,
  output logic [CH_W-1:0] o_channel,
  output logic [AW-1:0]   o_sample_idx,
  output logic            o_ch_wrap,
  output logic            o_pass_wrap
);

  logic [CH_W-1:0] r_ch;
  logic [AW-1:0]   r_idx;

  assign o_channel    = r_ch;
  assign o_sample_idx = r_idx;
  // next advance returns the channel to 0
  assign o_ch_wrap    = (r_ch == CH_W'(NUM_CHANNELS - 1));
  // sample index is at its last value; wraps when a channel wrap occurs
  assign o_pass_wrap  = (r_idx == AW'(DEPTH - 1));

  // Position update: clear wins over advance; index wraps naturally (DEPTH is 2^AW).
  always_ff @(posedge i_clock) begin
    if (!i_reset || i_clear) begin
      r_ch  <= '0;
      r_idx <= '0;
    end else if (i_advance) begin
      if (o_ch_wrap) begin
        r_ch  <= '0;
        r_idx <= r_idx + AW'(1);
      end else begin
        r_ch <= r_ch + CH_W'(1);
      end
    end
  end

endmodule

// File: rtl/agc_channel_sequencer.sv
// Walks interleaved (reference, error) channel streams from a synchronous ROM,
// hands each pair to the shared processor and returns channel-tagged results.
module agc_channel_sequencer
  import agc_seq_pkg::*;
#(
  parameter int DATA_SIZE       = 10,
  parameter int FRACTIONAL_SIZE = 8,
  parameter int NUM_CHANNELS    = 4,
  parameter int DEPTH           = 256,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic                                            i_clock,
  input  logic                                            i_reset,
  input  logic                                            i_enable,
  input  logic                                            i_mode,
  output logic [$clog2(NUM_CHANNELS)+$clog2(DEPTH)-1:0]   o_mem_addr,
  output logic                                            o_mem_rd,
  input  logic [DATA_SIZE-1:0]                            i_mem_reference,
  input  logic [DATA_SIZE-1:0]                            i_mem_error,
  output logic                                            o_proc_start,
  output logic [DATA_SIZE-1:0]                            o_proc_reference,
  output logic [DATA_SIZE-1:0]                            o_proc_error,
  input  logic [2*DATA_SIZE-1:0]                          i_proc_result,
  input  logic                                            i_proc_valid,
  output logic [2*DATA_SIZE-1:0]                          o_result,
  output logic [$clog2(NUM_CHANNELS)-1:0]                 o_result_channel,
  output logic                                            o_result_valid,
  output logic                                            o_busy,
  output logic                                            o_done,
  output logic                                            o_timeout
);

  localparam int CH_W   = $clog2(NUM_CHANNELS);
  localparam int AW     = $clog2(DEPTH);
  localparam int ADDR_W = CH_W + AW;
  localparam int TW     = $clog2(TIMEOUT_CYCLES) + 1;

  // Result fraction width is a property of the processor; it only constrains legal sizes here.
  if (NUM_CHANNELS < 2 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
      TIMEOUT_CYCLES < 2 || FRACTIONAL_SIZE > 2 * DATA_SIZE) begin : g_bad_params
    $error("agc_channel_sequencer: unsupported parameter set");
  end

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_mode;
  logic [TW-1:0]   r_tmo_cnt;
  logic [TW-1:0]   w_cnt_inc;
  logic            w_tmo_hit;
  logic [CH_W-1:0] w_channel;
  logic [AW-1:0]   w_sample_idx;
  logic            w_ch_wrap;
  logic            w_pass_wrap;
  logic            w_advance;
  logic            w_clear;

  assign w_advance = (r_state == S_ADVANCE);
  // leaving DONE restarts the walk from position 0
  assign w_clear   = (r_state == S_DONE) && !i_enable;

  agc_position_counter #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .DEPTH        (DEPTH),
    .CH_W         (CH_W),
    .AW           (AW)
  ) u_pos (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_advance    (w_advance),
    .i_clear      (w_clear),
    .o_channel    (w_channel),
    .o_sample_idx (w_sample_idx),
    .o_ch_wrap    (w_ch_wrap),
    .o_pass_wrap  (w_pass_wrap)
  );

  assign o_mem_addr = ADDR_W'(pack_addr(32'(w_sample_idx), 32'(w_channel), CH_W));

  // Counter is cleared in START, so after k WAIT_PROC cycles it holds k; expiry when
  // the k-th cycle would bring it to TIMEOUT_CYCLES-1.
  assign w_cnt_inc = r_tmo_cnt + TW'(1);
  assign w_tmo_hit = (w_cnt_inc == TW'(TIMEOUT_CYCLES - 1));

  // Next-state decode; valid beats a same-cycle timeout expiry.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (i_enable) w_state_nxt = S_FETCH;
      S_FETCH:     w_state_nxt = S_WAIT_MEM;
      S_WAIT_MEM:  w_state_nxt = S_START;
      S_START:     w_state_nxt = S_WAIT_PROC;
      S_WAIT_PROC: begin
        if (i_proc_valid)   w_state_nxt = S_EMIT;
        else if (w_tmo_hit) w_state_nxt = S_ADVANCE;
      end
      S_EMIT:      w_state_nxt = S_ADVANCE;
      S_ADVANCE: begin
        if (w_ch_wrap && w_pass_wrap && r_mode == MODE_SINGLE) w_state_nxt = S_DONE;
        else if (!i_enable)                                    w_state_nxt = S_IDLE;
        else                                                   w_state_nxt = S_FETCH;
      end
      S_DONE:      if (!i_enable) w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state, datapath registers and registered strobes decoded from the next state.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state          <= S_IDLE;
      r_mode           <= MODE_CONTINUOUS;
      r_tmo_cnt        <= '0;
      o_mem_rd         <= 1'b0;
      o_proc_start     <= 1'b0;
      o_proc_reference <= '0;
      o_proc_error     <= '0;
      o_result         <= '0;
      o_result_channel <= '0;
      o_result_valid   <= 1'b0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
      o_timeout        <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      o_mem_rd       <= (w_state_nxt == S_FETCH);
      o_proc_start   <= (w_state_nxt == S_START);
      o_result_valid <= (w_state_nxt == S_EMIT);
      o_done         <= (w_state_nxt == S_DONE);
      o_busy         <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);

      if (r_state == S_IDLE && i_enable) r_mode <= i_mode;

      if (r_state == S_WAIT_MEM) begin
        o_proc_reference <= i_mem_reference;
        o_proc_error     <= i_mem_error;
      end

      if (r_state == S_START) begin
        r_tmo_cnt <= '0;
      end else if (r_state == S_WAIT_PROC) begin
        if (i_proc_valid) begin
          o_result         <= i_proc_result;
          o_result_channel <= w_channel;
        end else begin
          r_tmo_cnt <= w_cnt_inc;
          if (w_tmo_hit) o_timeout <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_agc_channel_sequencer.sv
// Directed bench: ROM word = address (error = address+100), mock processor
// answers {ref,err} five cycles after start.
module tb_agc_channel_sequencer;

  localparam int DS = 10;
  localparam int NC = 2;
  localparam int DP = 4;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          i_reset, i_enable, i_mode;
  logic [2:0]    o_mem_addr;
  logic          o_mem_rd;
  logic [DS-1:0] rom_ref = '0, rom_err = '0;
  logic          o_proc_start;
  logic [DS-1:0] o_proc_reference, o_proc_error;
  logic [2*DS-1:0] mk_res = '0;
  logic          mk_valid = 1'b0;
  logic          spur = 1'b0;
  logic          i_proc_valid;
  logic [2*DS-1:0] o_result;
  logic          o_result_channel;
  logic          o_result_valid, o_busy, o_done, o_timeout;

  bit         drop_en = 1'b0;
  logic [2:0] drop_addr = '0;
  logic [2:0] mk_fa = '0, mk_a = '0;
  int         mk_cnt = 0;

  int checks = 0, failures = 0, cyc = 0, last_pv_cyc = -100;
  bit done_seen = 1'b0;
  int fa_q[$], fc_q[$], rr_q[$], rc_q[$];

  typedef struct { int addr; int ch; int res; } vec_t;
  vec_t tbl[8];

  always #5 clk = ~clk;

  assign i_proc_valid = mk_valid | spur;

  agc_channel_sequencer #(
    .DATA_SIZE(DS), .FRACTIONAL_SIZE(8), .NUM_CHANNELS(NC), .DEPTH(DP), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clock(clk), .i_reset(i_reset), .i_enable(i_enable), .i_mode(i_mode),
    .o_mem_addr(o_mem_addr), .o_mem_rd(o_mem_rd),
    .i_mem_reference(rom_ref), .i_mem_error(rom_err),
    .o_proc_start(o_proc_start), .o_proc_reference(o_proc_reference), .o_proc_error(o_proc_error),
    .i_proc_result(mk_res), .i_proc_valid(i_proc_valid),
    .o_result(o_result), .o_result_channel(o_result_channel), .o_result_valid(o_result_valid),
    .o_busy(o_busy), .o_done(o_done), .o_timeout(o_timeout)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // synchronous ROM and mock processor
  always @(posedge clk) begin
    if (o_mem_rd) begin
      rom_ref <= {7'd0, o_mem_addr};
      rom_err <= {7'd0, o_mem_addr} + 10'd100;
      mk_fa   <= o_mem_addr;
    end
    mk_valid <= 1'b0;
    if (o_proc_start) begin
      mk_cnt <= 4;
      mk_res <= {o_proc_reference, o_proc_error};
      mk_a   <= mk_fa;
    end else if (mk_cnt > 0) begin
      mk_cnt <= mk_cnt - 1;
      if (mk_cnt == 1 && !(drop_en && mk_a == drop_addr)) mk_valid <= 1'b1;
    end
  end

  // monitor: fetch/result logs and valid-to-result latency
  always @(negedge clk) begin
    cyc++;
    if (o_mem_rd) begin fa_q.push_back(int'(o_mem_addr)); fc_q.push_back(cyc); end
    if (o_result_valid) begin
      rr_q.push_back(int'(o_result));
      rc_q.push_back(int'(o_result_channel));
      chk("valid_to_result_lat", cyc - last_pv_cyc, 1);
    end
    if (i_proc_valid) last_pv_cyc = cyc;
    if (o_done) done_seen = 1'b1;
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic wait_fetch(input int a, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (o_mem_rd && int'(o_mem_addr) == a) begin ok = 1'b1; return; end
    end
  endtask

  task automatic wait_rd(output int a, output bit ok);
    ok = 1'b0; a = -1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (o_mem_rd) begin a = int'(o_mem_addr); ok = 1'b1; return; end
    end
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (o_proc_start) begin ok = 1'b1; return; end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (!o_busy) begin ok = 1'b1; return; end
    end
  endtask

  task automatic do_reset();
    i_reset = 1'b0; i_enable = 1'b0;
    tick(); tick();
    i_reset = 1'b1;
    tick();
  endtask

  task automatic clear_logs();
    fa_q.delete(); fc_q.delete(); rr_q.delete(); rc_q.delete();
  endtask

  initial begin
    bit ok;
    int a, s_cyc, n;

    // result = {ref, err} = {addr, addr+100} = addr*1024 + addr + 100
    tbl[0] = '{0, 0, 100};  tbl[1] = '{1, 1, 1125};
    tbl[2] = '{2, 0, 2150}; tbl[3] = '{3, 1, 3175};
    tbl[4] = '{4, 0, 4200}; tbl[5] = '{5, 1, 5225};
    tbl[6] = '{6, 0, 6250}; tbl[7] = '{7, 1, 7275};

    i_reset = 1'b0; i_enable = 1'b0; i_mode = 1'b0;
    repeat (3) tick();
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_done", int'(o_done), 0);
    chk("rst_timeout", int'(o_timeout), 0);
    chk("rst_mem_rd", int'(o_mem_rd), 0);
    chk("rst_addr", int'(o_mem_addr), 0);
    chk("rst_start", int'(o_proc_start), 0);
    chk("rst_result_valid", int'(o_result_valid), 0);
    i_reset = 1'b1;
    tick();

    // single pass; mode change after launch must not matter
    clear_logs();
    i_mode = 1'b1; i_enable = 1'b1;
    repeat (15) tick();
    i_mode = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (o_done) begin ok = 1'b1; break; end
    end
    chk("single_wait_done", int'(ok), 1);
    chk("single_result_count", rr_q.size(), 8);
    chk("single_fetch_count", fa_q.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("single_addr[%0d]", i), (i < fa_q.size()) ? fa_q[i] : -1, tbl[i].addr);
      chk($sformatf("single_ch[%0d]", i), (i < rc_q.size()) ? rc_q[i] : -1, tbl[i].ch);
      chk($sformatf("single_res[%0d]", i), (i < rr_q.size()) ? rr_q[i] : -1, tbl[i].res);
    end
    chk("single_busy_at_done", int'(o_busy), 0);
    repeat (3) tick();
    chk("single_done_held", int'(o_done), 1);
    i_enable = 1'b0;
    tick();
    chk("single_done_cleared", int'(o_done), 0);

    // continuous mode: 20 samples, wrap 7->0 without a gap
    clear_logs();
    done_seen = 1'b0;
    i_enable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (rr_q.size() >= 20) begin ok = 1'b1; break; end
    end
    chk("cont_wait_20", int'(ok), 1);
    i_enable = 1'b0;
    wait_idle(ok);
    chk("cont_wait_idle", int'(ok), 1);
    chk("cont_fetch_count", fa_q.size(), 20);
    n = (fa_q.size() < 20) ? fa_q.size() : 20;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("cont_addr[%0d]", i), fa_q[i], i % 8);
      if (i > 0) chk($sformatf("cont_gap[%0d]", i), fc_q[i] - fc_q[i-1], 10);
    end
    chk("cont_res_ch[8]", (rc_q.size() > 8) ? rc_q[8] : -1, 0);
    chk("cont_res[8]", (rr_q.size() > 8) ? rr_q[8] : -1, 100);
    chk("cont_no_done", int'(done_seen), 0);

    // drop enable during WAIT_PROC of address 3
    do_reset();
    clear_logs();
    i_mode = 1'b0; i_enable = 1'b1;
    wait_fetch(3, ok); chk("pause_wait_fetch3", int'(ok), 1);
    wait_start(ok);    chk("pause_wait_start3", int'(ok), 1);
    tick();
    i_enable = 1'b0;
    wait_idle(ok);     chk("pause_wait_idle", int'(ok), 1);
    chk("pause_res_count", rr_q.size(), 4);
    chk("pause_last_res", (rr_q.size() > 0) ? rr_q[$] : -1, 3175);
    chk("pause_last_ch", (rc_q.size() > 0) ? rc_q[$] : -1, 1);
    repeat (5) tick();
    chk("pause_no_fetch_idle", fa_q.size(), 4);
    i_enable = 1'b1;
    wait_rd(a, ok);    chk("resume_wait_rd", int'(ok), 1);
    chk("resume_addr", a, 4);
    i_enable = 1'b0;
    wait_idle(ok);     chk("resume_wait_idle", int'(ok), 1);

    // processor never answers address 2
    do_reset();
    clear_logs();
    drop_addr = 3'd2; drop_en = 1'b1;
    i_enable = 1'b1;
    wait_fetch(2, ok); chk("tmo_wait_fetch2", int'(ok), 1);
    wait_start(ok);    chk("tmo_wait_start", int'(ok), 1);
    s_cyc = cyc;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (o_timeout) begin ok = 1'b1; break; end
    end
    chk("tmo_rise_seen", int'(ok), 1);
    chk("tmo_rise_delay", cyc - s_cyc, 8);
    wait_rd(a, ok);    chk("tmo_wait_rd", int'(ok), 1);
    chk("tmo_next_addr", a, 3);
    chk("tmo_no_result_addr2", rr_q.size(), 2);
    i_enable = 1'b0;
    wait_idle(ok);     chk("tmo_wait_idle", int'(ok), 1);
    chk("tmo_sticky", int'(o_timeout), 1);
    drop_en = 1'b0;

    // reset pulse during WAIT_PROC, then a late processor valid
    do_reset();
    chk("rst_clears_timeout", int'(o_timeout), 0);
    clear_logs();
    i_enable = 1'b1;
    wait_fetch(1, ok); chk("mid_wait_fetch1", int'(ok), 1);
    wait_start(ok);    chk("mid_wait_start", int'(ok), 1);
    tick(); tick();
    i_reset = 1'b0; i_enable = 1'b0;
    tick();
    i_reset = 1'b1;
    chk("mid_rst_busy", int'(o_busy), 0);
    chk("mid_rst_addr", int'(o_mem_addr), 0);
    chk("mid_rst_operand_ref", int'(o_proc_reference), 0);
    chk("mid_rst_operand_err", int'(o_proc_error), 0);
    chk("mid_rst_result", int'(o_result), 0);
    chk("mid_rst_start", int'(o_proc_start), 0);
    n = rr_q.size();
    repeat (6) tick();
    chk("late_valid_ignored", rr_q.size(), n);
    i_enable = 1'b1;
    wait_rd(a, ok);    chk("mid_rst_wait_rd", int'(ok), 1);
    chk("mid_rst_restart_addr", a, 0);
    i_enable = 1'b0;
    wait_idle(ok);     chk("mid_rst_wait_idle", int'(ok), 1);

    // spurious valid while fetching address 1
    do_reset();
    clear_logs();
    i_enable = 1'b1;
    wait_fetch(1, ok); chk("spur_wait_fetch1", int'(ok), 1);
    spur = 1'b1;
    tick();
    spur = 1'b0;
    chk("spur_ref_held", int'(o_proc_reference), 0);
    chk("spur_err_held", int'(o_proc_error), 100);
    tick();
    chk("spur_start", int'(o_proc_start), 1);
    chk("spur_ref_loaded", int'(o_proc_reference), 1);
    chk("spur_err_loaded", int'(o_proc_error), 101);
    i_enable = 1'b0;
    wait_idle(ok);     chk("spur_wait_idle", int'(ok), 1);
    chk("spur_res_count", rr_q.size(), 2);
    chk("spur_last_res", (rr_q.size() > 0) ? rr_q[$] : -1, 1125);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
